// File: rtl/addsub_arb.sv
// addsub_arb: two requesters share a single registered add/sub unit.
// A round-robin arbiter picks one request per IDLE cycle, captures that
// requester's operands and runs the operation IDLE -> GRANT -> RESP.
//
// Ports:
//   clk_i              rising-edge clock
//   reset_i            asynchronous, active-high reset
//   req0_i / req1_i    operation request from requester 0 / 1
//   a0_i, b0_i         requester 0 operands (WIDTH bits)
//   a1_i, b1_i         requester 1 operands (WIDTH bits)
//   mode0_i / mode1_i  0 = A+B, 1 = A-B
//   gnt0_o / gnt1_o    one-cycle grant pulse, operands captured
//   valid0_o/valid1_o  one-cycle pulse, result_o/ovf_o belong to requester
//   result_o           registered result, held until next RESP load
//   ovf_o              two's-complement signed overflow of last operation
//   busy_o             high whenever the FSM is not IDLE
module addsub_arb #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] a0_i,
    input  logic [WIDTH-1:0] b0_i,
    input  logic [WIDTH-1:0] a1_i,
    input  logic [WIDTH-1:0] b1_i,
    input  logic             mode0_i,
    input  logic             mode1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             valid0_o,
    output logic             valid1_o,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o,
    output logic             busy_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]       r_state;
    logic             r_winner;
    logic             r_last;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;

    logic             w_any_req;
    logic             w_pick;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    // Round robin: a lone request wins; on contention the requester that
    // was not served last wins.
    always_comb begin
        w_any_req = req0_i | req1_i;
        w_pick    = 1'b0;
        if (req0_i && req1_i) begin
            w_pick = ~r_last;
        end else if (req1_i) begin
            w_pick = 1'b1;
        end
    end

    // Single shared adder: subtraction is A + ~B + 1. Overflow occurs when
    // A and the effective B agree in sign but the sum does not.
    always_comb begin
        w_b_eff = r_mode ? ~r_b : r_b;
        w_sum   = r_a + w_b_eff + {{(WIDTH-1){1'b0}}, r_mode};
        w_ovf   = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != r_a[WIDTH-1]);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= S_IDLE;
            r_winner <= 1'b0;
            r_last   <= 1'b1;
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_winner <= w_pick;
                        r_last   <= w_pick;
                        r_a      <= w_pick ? a1_i    : a0_i;
                        r_b      <= w_pick ? b1_i    : b0_i;
                        r_mode   <= w_pick ? mode1_i : mode0_i;
                        r_state  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_result <= w_sum;
                    r_ovf    <= w_ovf;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pulses decode directly from registered state so reset clears them
    // without waiting for a clock.
    always_comb begin
        gnt0_o   = (r_state == S_GRANT) && !r_winner;
        gnt1_o   = (r_state == S_GRANT) &&  r_winner;
        valid0_o = (r_state == S_RESP)  && !r_winner;
        valid1_o = (r_state == S_RESP)  &&  r_winner;
        busy_o   = (r_state != S_IDLE);
        result_o = r_result;
        ovf_o    = r_ovf;
    end

endmodule

// File: tb/tb_addsub_arb.sv
// tb_addsub_arb: directed and randomized checks of addsub_arb against a
// transaction-level reference model (winner choice plus signed integer
// arithmetic, scheduled as grant one cycle and result two cycles later).
module tb_addsub_arb;

    localparam int W = 5;

    logic         clk;
    logic         reset_i;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         mode0, mode1;
    logic         gnt0, gnt1, valid0, valid1, ovf, busy;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    int m_left;
    int m_last;
    int m_win;
    int p_res;
    int p_ovf;
    logic e_gnt0, e_gnt1, e_val0, e_val1, e_busy, e_ovf;
    logic [W-1:0] e_res;

    addsub_arb #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .req0_i   (req0),
        .req1_i   (req1),
        .a0_i     (a0),
        .b0_i     (b0),
        .a1_i     (a1),
        .b1_i     (b1),
        .mode0_i  (mode0),
        .mode1_i  (mode1),
        .gnt0_o   (gnt0),
        .gnt1_o   (gnt1),
        .valid0_o (valid0),
        .valid1_o (valid1),
        .result_o (result),
        .ovf_o    (ovf),
        .busy_o   (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left = 0;
        m_last = 1;
        m_win  = 0;
        e_gnt0 = 0; e_gnt1 = 0; e_val0 = 0; e_val1 = 0;
        e_busy = 0; e_ovf  = 0; e_res  = '0;
    endtask

    function automatic int to_signed(input logic [W-1:0] v);
        int x;
        x = int'(v);
        if (x >= (1 << (W-1))) x = x - (1 << W);
        return x;
    endfunction

    task automatic check_outputs(input string ph);
        check({ph, ".gnt0"},   gnt0,   e_gnt0);
        check({ph, ".gnt1"},   gnt1,   e_gnt1);
        check({ph, ".valid0"}, valid0, e_val0);
        check({ph, ".valid1"}, valid1, e_val1);
        check({ph, ".busy"},   busy,   e_busy);
        check({ph, ".result"}, result, e_res);
        check({ph, ".ovf"},    ovf,    e_ovf);
    endtask

    // One clock cycle: check what the previous edge produced, then drive
    // the inputs for the coming edge and predict its outcome.
    task automatic step(input string ph, input logic r0, input logic r1,
                        input logic [W-1:0] xa0, input logic [W-1:0] xb0, input logic xm0,
                        input logic [W-1:0] xa1, input logic [W-1:0] xb1, input logic xm1);
        int sa, sb, r;
        @(negedge clk);
        check_outputs(ph);
        req0 = r0; req1 = r1;
        a0 = xa0; b0 = xb0; mode0 = xm0;
        a1 = xa1; b1 = xb1; mode1 = xm1;
        e_gnt0 = 0; e_gnt1 = 0; e_val0 = 0; e_val1 = 0;
        if (m_left == 0) begin
            if (r0 || r1) begin
                if (r0 && r1) m_win = (m_last == 0) ? 1 : 0;
                else          m_win = r1 ? 1 : 0;
                m_last = m_win;
                sa = to_signed(m_win ? xa1 : xa0);
                sb = to_signed(m_win ? xb1 : xb0);
                r  = (m_win ? xm1 : xm0) ? sa - sb : sa + sb;
                p_ovf = (r > (1 << (W-1)) - 1 || r < -(1 << (W-1))) ? 1 : 0;
                p_res = r & ((1 << W) - 1);
                if (m_win == 0) e_gnt0 = 1; else e_gnt1 = 1;
                e_busy = 1;
                m_left = 2;
            end else begin
                e_busy = 0;
            end
        end else if (m_left == 2) begin
            if (m_win == 0) e_val0 = 1; else e_val1 = 1;
            e_res  = p_res[W-1:0];
            e_ovf  = p_ovf[0];
            e_busy = 1;
            m_left = 1;
        end else begin
            e_busy = 0;
            m_left = 0;
        end
    endtask

    task automatic idle(input string ph);
        step(ph, 0, 0, '0, '0, 0, '0, '0, 0);
    endtask

    initial begin
        reset_i = 1'b1;
        req0 = 0; req1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0; mode0 = 0; mode1 = 0;
        model_reset();
        #2;
        check_outputs("reset0");
        @(negedge clk);
        reset_i = 1'b0;

        // single add 3+4
        step("add", 1, 0, 5'd3, 5'd4, 0, '0, '0, 0);
        idle("add_g");
        check("add_gnt0", gnt0, 1);
        idle("add_v");
        check("add_res", result, 7);
        check("add_ovf", ovf, 0);
        idle("add_i");

        // subtract wrap 2-5
        step("sub", 0, 1, '0, '0, 0, 5'd2, 5'd5, 1);
        idle("sub_g");
        idle("sub_v");
        check("sub_valid1", valid1, 1);
        check("sub_res", result, 29);
        idle("sub_i");

        // overflow add 15+1 and sub 16-1
        step("ovfa", 1, 0, 5'd15, 5'd1, 0, '0, '0, 0);
        idle("ovfa_g");
        idle("ovfa_v");
        check("ovfa_res", result, 16);
        check("ovfa_ovf", ovf, 1);
        step("ovfs", 1, 0, 5'd16, 5'd1, 1, '0, '0, 0);
        idle("ovfs_g");
        idle("ovfs_v");
        check("ovfs_res", result, 15);
        check("ovfs_ovf", ovf, 1);
        // inputs changing mid-flight and held result
        step("hold", 1, 0, 5'd1, 5'd1, 0, '0, '0, 0);
        step("hold_g", 1, 1, 5'd9, 5'd9, 1, 5'd7, 5'd3, 0);
        step("hold_v", 0, 0, 5'd30, 5'd2, 1, '0, '0, 0);
        check("hold_res", result, 2);
        idle("hold_i");
        idle("hold_i2");
        check("hold_keep", result, 2);

        // contention after reset: order 0,1,0,1
        @(posedge clk); #2;
        reset_i = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_mid");
        @(negedge clk);
        reset_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step("cont", 1, 1, 5'(i), 5'd1, 0, 5'(i + 8), 5'd2, 1);
            step("cont_g", 1, 1, 5'(i), 5'd1, 0, 5'(i + 8), 5'd2, 1);
            check("cont_order", {gnt1, gnt0}, (i % 2 == 1) ? 2 : 1);
            step("cont_v", 1, 1, 5'(i), 5'd1, 0, 5'(i + 8), 5'd2, 1);
        end
        idle("cont_i");

        // reset during GRANT aborts, then requester 0 wins first
        step("abort", 1, 0, 5'd6, 5'd6, 0, '0, '0, 0);
        @(posedge clk); #2;
        check("abort_busy_pre", busy, 1);
        reset_i = 1'b1;
        req0 = 0;
        #1;
        model_reset();
        check_outputs("abort_rst");
        @(negedge clk);
        check_outputs("abort_held");
        reset_i = 1'b0;
        idle("abort_i");
        step("post", 1, 1, 5'd1, 5'd2, 0, 5'd3, 5'd4, 0);
        idle("post_g");
        check("post_gnt0", gnt0, 1);
        idle("post_v");
        check("post_val0", valid0, 1);
        check("post_res", result, 3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom), 1'($urandom),
                 W'($urandom), W'($urandom), 1'($urandom),
                 W'($urandom), W'($urandom), 1'($urandom));
        end
        idle("end0");
        idle("end1");
        idle("end2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        n_errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/addsub_arb.md
ADDSUB_ARB -- requirements
Module: addsub_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, operand/result width in bits.
REQ-002 The block SHALL have port clk_i  input  1  clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have ports req0_i / req1_i  input  1  operation request from requester 0 / 1.
REQ-005 The block SHALL have ports a0_i, b0_i / a1_i, b1_i  input  WIDTH  operands A and B per requester.
REQ-006 The block SHALL have ports mode0_i / mode1_i  input  1  per-requester operation select: 0 = A+B, 1 = A-B.
REQ-007 The block SHALL have ports gnt0_o / gnt1_o  output  1  one-cycle grant pulse: operands captured.
REQ-008 The block SHALL have ports valid0_o / valid1_o  output  1  one-cycle pulse: result_o/ovf_o belong to this requester.
REQ-009 The block SHALL have port result_o  output  WIDTH  registered result of the shared add/sub unit.
REQ-010 The block SHALL have port ovf_o  output  1  two's-complement signed overflow of last operation.
REQ-011 The block SHALL have port busy_o  output  1  high whenever FSM is not IDLE.

Function
REQ-012 The block SHALL contain exactly one add/sub datapath shared by both requesters.
REQ-013 The FSM SHALL have states IDLE, GRANT, RESP; sequence IDLE -> GRANT -> RESP -> IDLE.
REQ-014 Requests SHALL be sampled only in IDLE; IDLE with no request stays IDLE.
REQ-015 On the edge ending an IDLE cycle with a request, the block SHALL latch the winner's a, b, mode, record winner ID, and enter GRANT.
REQ-016 In GRANT, gntX_o of the winner SHALL be high for exactly that cycle; all other gnt/valid low.
REQ-017 On the edge ending GRANT, result_o SHALL load (A+B) or (A-B) mod 2^WIDTH from latched operands, ovf_o SHALL load the signed-overflow flag, and the FSM SHALL enter RESP.
REQ-018 ovf_o SHALL be 1 for add iff A,B same sign and result sign differs; for sub iff A,B differ in sign and result sign differs from A.
REQ-019 In RESP, validX_o of the winner SHALL be high for exactly that cycle; FSM returns to IDLE next edge.
REQ-020 Latency SHALL be: request sampled in cycle N -> gnt in N+1 -> valid in N+2; max throughput one op per 3 cycles.
REQ-021 result_o and ovf_o SHALL hold their values until the next RESP load.
REQ-022 Input changes during GRANT/RESP SHALL NOT affect the in-flight operation.
REQ-023 Arbitration SHALL be round-robin on a last-served pointer: single request wins; both requesting -> the one not last served wins.
REQ-024 The last-served pointer SHALL update on the IDLE->GRANT edge to the winner.
REQ-025 Requesters SHALL drop req after gnt; a req still high in the next IDLE cycle SHALL be treated as a new request.
REQ-026 busy_o SHALL be high in GRANT and RESP, low in IDLE.

Reset
REQ-027 While reset_i is high, the FSM SHALL be IDLE and result_o, ovf_o, all gnt/valid, busy_o SHALL be 0, regardless of clock.
REQ-028 Reset SHALL set the last-served pointer to 1 so requester 0 wins the first contested arbitration.
REQ-029 Reset asserted in GRANT or RESP SHALL abort the operation with no valid pulse; the request is not retried automatically.

Verification
REQ-030 Reset: assert reset_i mid-cycle without clock -> all outputs 0 immediately, busy_o 0.
REQ-031 Single add: req0, a0=3, b0=4, mode0=0 -> gnt0 next cycle, valid0 cycle after, result_o=7, ovf_o=0.
REQ-032 Subtract wrap: req1, a1=2, b1=5, mode1=1 -> valid1 with result_o=29 (5'h1D), ovf_o=0.
REQ-033 Overflow: req0, a0=15, b0=1, mode0=0 -> result_o=16, ovf_o=1; a0=16, b0=1, mode0=1 -> result_o=15, ovf_o=1.
REQ-034 Contention: req0 and req1 held high from reset -> grant order 0,1,0,1 with a gnt every 3 cycles, each valid matching its operands.
REQ-035 Reset mid-op: req0 accepted, reset_i pulsed during GRANT -> no valid0, outputs 0; after release with req0,req1 high -> requester 0 granted first.
